// File: rtl/plp_pkg.sv
// Shared types and default sizing for the length-prepend block.
package plp_pkg;

  typedef enum logic [1:0] {WAIT_SOP, IN_PKT, DROP} in_st_e;
  typedef enum logic [1:0] {IDLE, HDR, DATA} out_st_e;

  localparam int PLP_DATA_W     = 8;
  localparam int PLP_LEN_W      = 16;
  localparam int PLP_DATA_DEPTH = 2048;
  localparam int PLP_LEN_DEPTH  = 16;
  localparam int PLP_MAX_LEN    = 1500;

  localparam int HDR_BEATS = PLP_LEN_W / PLP_DATA_W;
  localparam int DATA_AW   = $clog2(PLP_DATA_DEPTH);
  localparam int LEN_AW    = $clog2(PLP_LEN_DEPTH);

endpackage

// File: rtl/plp_sync_fifo.sv
// Small synchronous FIFO with combinational read of the head entry.
module plp_sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp, rp;
  logic         do_push, do_pop;

  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty   = (wp == rp);
  assign dout    = mem[rp[AW-1:0]];
  // a push into a full queue is fine when the head leaves in the same cycle
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/pkt_len_prepend.sv
// Buffers packets and re-emits each one behind an MSB-first beat-count header.
// Define PLP_STATS_EN to add the pkt_cnt / drop_cnt statistics outputs.
module pkt_len_prepend
  import plp_pkg::*;
#(
  parameter int DATA_W     = PLP_DATA_W,
  parameter int LEN_W      = PLP_LEN_W,
  parameter int DATA_DEPTH = PLP_DATA_DEPTH,
  parameter int LEN_DEPTH  = PLP_LEN_DEPTH,
  parameter int MAX_LEN    = PLP_MAX_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_sop,
  input  logic              din_eop,
  input  logic              din_vld,
  output logic              din_rdy,
  output logic [DATA_W-1:0] dout,
  output logic              dout_sop,
  output logic              dout_eop,
  output logic              dout_vld,
  input  logic              dout_rdy,
  output logic              drop_pulse
`ifdef PLP_STATS_EN
  ,
  output logic [31:0]       pkt_cnt,
  output logic [31:0]       drop_cnt
`endif
);
  localparam int AW = $clog2(DATA_DEPTH);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] HLAST = LEN_W'(LEN_W / DATA_W - 1);

  logic [DATA_W-1:0] mem [DATA_DEPTH];
  logic [AW:0]       wr_ptr, wr_commit, rd_ptr;
  logic [LEN_W-1:0]  cnt, len_din, len_q, hsr, hsr_nx, hleft, bcnt, len_r;
  logic [AW-1:0]     mem_wa;
  logic              mem_we, len_push, len_pop, len_full, len_empty;
  logic              data_full, acc, restart, over;
  in_st_e            in_st;
  out_st_e           out_st;

  assign data_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign din_rdy   = !rst && !data_full && !len_full;
  assign acc       = din_vld && din_rdy;

  always_comb begin
    mem_we   = 1'b0;
    mem_wa   = wr_ptr[AW-1:0];
    len_push = 1'b0;
    len_din  = cnt + 1'b1;
    restart  = 1'b0;
    over     = 1'b0;
    if (acc) begin
      case (in_st)
        WAIT_SOP: if (din_sop) begin
          mem_we   = 1'b1;
          len_push = din_eop;
          len_din  = LEN_W'(1);
        end
        IN_PKT: if (din_sop) begin
          // new sop abandons the open packet and reuses its slot
          restart  = 1'b1;
          mem_we   = 1'b1;
          mem_wa   = wr_commit[AW-1:0];
          len_push = din_eop;
          len_din  = LEN_W'(1);
        end else if (cnt >= MAX_L) begin
          over = 1'b1;
        end else begin
          mem_we   = 1'b1;
          len_push = din_eop;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk)
    if (mem_we) mem[mem_wa] <= din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_st      <= WAIT_SOP;
      wr_ptr     <= '0;
      wr_commit  <= '0;
      cnt        <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= 1'b0;
      if (acc) begin
        case (in_st)
          WAIT_SOP: if (din_sop) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (din_eop) wr_commit <= wr_ptr + 1'b1;
            else begin
              cnt   <= LEN_W'(1);
              in_st <= IN_PKT;
            end
          end
          IN_PKT: if (restart) begin
            drop_pulse <= 1'b1;
            wr_ptr     <= wr_commit + 1'b1;
            if (din_eop) begin
              wr_commit <= wr_commit + 1'b1;
              in_st     <= WAIT_SOP;
            end else cnt <= LEN_W'(1);
          end else if (over) begin
            drop_pulse <= 1'b1;
            wr_ptr     <= wr_commit;
            in_st      <= din_eop ? WAIT_SOP : DROP;
          end else begin
            wr_ptr <= wr_ptr + 1'b1;
            cnt    <= cnt + 1'b1;
            if (din_eop) begin
              wr_commit <= wr_ptr + 1'b1;
              in_st     <= WAIT_SOP;
            end
          end
          DROP: if (din_eop) in_st <= WAIT_SOP;
          default: in_st <= WAIT_SOP;
        endcase
      end
    end
  end

  plp_sync_fifo #(.W(LEN_W), .DEPTH(LEN_DEPTH)) u_len_q (
    .clk   (clk),
    .rst   (rst),
    .push  (len_push),
    .din   (len_din),
    .pop   (len_pop),
    .dout  (len_q),
    .full  (len_full),
    .empty (len_empty)
  );

  // popping straight out of the last payload beat gives gapless back-to-back packets
  assign len_pop = !len_empty && (out_st == IDLE || (out_st == DATA && dout_rdy && dout_eop));
  assign hsr_nx  = hsr << DATA_W;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_st   <= IDLE;
      dout     <= '0;
      dout_sop <= 1'b0;
      dout_eop <= 1'b0;
      dout_vld <= 1'b0;
      rd_ptr   <= '0;
      hsr      <= '0;
      hleft    <= '0;
      bcnt     <= '0;
      len_r    <= '0;
    end else if (len_pop) begin
      len_r    <= len_q;
      hsr      <= len_q;
      hleft    <= HLAST;
      dout     <= len_q[LEN_W-1 -: DATA_W];
      dout_sop <= 1'b1;
      dout_eop <= 1'b0;
      dout_vld <= 1'b1;
      out_st   <= HDR;
    end else begin
      case (out_st)
        HDR: if (dout_rdy) begin
          dout_sop <= 1'b0;
          if (hleft == '0) begin
            dout     <= mem[rd_ptr[AW-1:0]];
            rd_ptr   <= rd_ptr + 1'b1;
            bcnt     <= LEN_W'(1);
            dout_eop <= (len_r == LEN_W'(1));
            out_st   <= DATA;
          end else begin
            hsr   <= hsr_nx;
            dout  <= hsr_nx[LEN_W-1 -: DATA_W];
            hleft <= hleft - 1'b1;
          end
        end
        DATA: if (dout_rdy) begin
          if (dout_eop) begin
            dout_vld <= 1'b0;
            dout_eop <= 1'b0;
            out_st   <= IDLE;
          end else begin
            dout     <= mem[rd_ptr[AW-1:0]];
            rd_ptr   <= rd_ptr + 1'b1;
            bcnt     <= bcnt + 1'b1;
            dout_eop <= (bcnt + 1'b1 == len_r);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PLP_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (out_st == DATA && dout_rdy && dout_eop) pkt_cnt <= pkt_cnt + 1'b1;
      if (drop_pulse) drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule
